// File: rtl/irq_ctrl_pkg.sv
// Shared types, default parameters and helper functions for the irq_ctrl interrupt controller.
package irq_ctrl_pkg;

   typedef enum logic [0:0] {StIdle, StReq} state_e;

   localparam int unsigned DefNumIrq    = 3;
   localparam int unsigned MaxIrq       = 32;
   localparam logic [31:0] DefVecBase   = 32'h0000_0400;
   localparam logic [31:0] DefVecStride = 32'h0000_0040;

   function automatic logic [31:0] vec_addr(input int unsigned idx,
                                            input logic [31:0] base   = DefVecBase,
                                            input logic [31:0] stride = DefVecStride);
      return base + 32'(idx) * stride;
   endfunction

   // Highest set bit index, -1 when the mask is empty.
   function automatic int top_index(input logic [MaxIrq-1:0] mask);
      int idx;
      idx = -1;
      for (int i = 0; i < MaxIrq; i++) begin
         if (mask[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser for one raw interrupt line, followed by a registered rising-edge pulse.
module irq_sync_edge
   import irq_ctrl_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic irq_i,
   output logic edge_o
);

   logic s1_q, s2_q, s3_q, edge_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         s3_q   <= 1'b0;
         edge_q <= 1'b0;
      end else begin
         s1_q   <= irq_i;
         s2_q   <= s1_q;
         s3_q   <= s2_q;
         edge_q <= s2_q & ~s3_q;
      end
   end

   assign edge_o = edge_q;

endmodule

// File: rtl/irq_ctrl.sv
// Prioritised external-interrupt controller with EPC stack feeding the CPU PC-select logic.
// Nested handlers are enabled by defining IRQ_CTRL_NEST_EN; otherwise one handler at a time.
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int unsigned NUM_IRQ    = DefNumIrq,
   parameter logic [31:0] VEC_BASE   = DefVecBase,
   parameter logic [31:0] VEC_STRIDE = DefVecStride
) (
   input  logic               clk,
   input  logic               in_RST,
   input  logic               en,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic [31:0]        resume_pc,
   input  logic               wb_eret,
   input  logic               int_ack,
   output logic               int_req,
   output logic [31:0]        int_addr,
   output logic [31:0]        epc,
   output logic [NUM_IRQ-1:0] pending,
   output logic [NUM_IRQ-1:0] in_service,
   output logic               eret_err
);

`ifdef IRQ_CTRL_NEST_EN
   localparam int unsigned Depth = NUM_IRQ;
   localparam bit          Nest  = 1'b1;
`else
   localparam int unsigned Depth = 1;
   localparam bit          Nest  = 1'b0;
`endif
   localparam int unsigned SpW  = $clog2(Depth + 1);
   localparam int unsigned SelW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

   state_e             state_q, state_d;
   logic [SelW-1:0]    sel_q, sel_d;
   logic [NUM_IRQ-1:0] pend_q, pend_d;
   logic [NUM_IRQ-1:0] insvc_q, insvc_d;
   logic [NUM_IRQ-1:0] edges, elig;
   logic [31:0]        stack_q [Depth];
   logic [31:0]        stack_d [Depth];
   logic [SpW-1:0]     sp_q, sp_d;
   logic               err_q, err_d;
   logic               eret_go;
   int                 hi, win;

   for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
      irq_sync_edge u_sync (
         .clk_i  (clk),
         .rst_i  (in_RST),
         .irq_i  (irq_in[g]),
         .edge_o (edges[g])
      );
   end

   always_comb begin
      hi = top_index(MaxIrq'(insvc_q));
      for (int i = 0; i < NUM_IRQ; i++) begin
         elig[i] = pend_q[i] && (Nest ? (i > hi) : (hi < 0));
      end
      win = top_index(MaxIrq'(elig));
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      pend_d  = pend_q;
      insvc_d = insvc_q;
      stack_d = stack_q;
      sp_d    = sp_q;
      err_d   = err_q;
      eret_go = wb_eret & en;

      if (eret_go) begin
         if (sp_q == '0) begin
            err_d = 1'b1;
         end else begin
            sp_d = sp_q - 1'b1;
            if (Nest) begin
               for (int i = 0; i < NUM_IRQ; i++) begin
                  if (i == hi) insvc_d[i] = 1'b0;
               end
            end else begin
               insvc_d = '0;
            end
         end
      end

      if (en) begin
         case (state_q)
            StIdle: begin
               // A coincident eret wins; eligibility is re-evaluated next cycle.
               if (!eret_go && win >= 0) begin
                  sel_d   = SelW'(win);
                  state_d = StReq;
               end
            end
            StReq: begin
               if (int_ack) begin
                  pend_d[sel_q]  = 1'b0;
                  insvc_d[sel_q] = 1'b1;
                  stack_d[sp_d]  = resume_pc;
                  sp_d           = sp_d + 1'b1;
                  state_d        = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end

      // New edges are merged after the ack clear so a same-cycle edge is kept.
      pend_d = pend_d | edges;
   end

   always_ff @(posedge clk) begin
      if (in_RST) begin
         state_q <= StIdle;
         sel_q   <= '0;
         pend_q  <= '0;
         insvc_q <= '0;
         sp_q    <= '0;
         err_q   <= 1'b0;
         for (int unsigned i = 0; i < Depth; i++) stack_q[i] <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         pend_q  <= pend_d;
         insvc_q <= insvc_d;
         sp_q    <= sp_d;
         err_q   <= err_d;
         stack_q <= stack_d;
      end
   end

   assign int_req    = (state_q == StReq);
   assign int_addr   = int_req ? vec_addr(32'(sel_q), VEC_BASE, VEC_STRIDE) : 32'h0;
   assign epc        = (sp_q == '0) ? 32'h0 : stack_q[sp_q - 1'b1];
   assign pending    = pend_q;
   assign in_service = insvc_q;
   assign eret_err   = err_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus randomized traffic against a queue model.
module tb_irq_ctrl;

   localparam int          NUM = 3;
   localparam logic [31:0] VB  = 32'h0000_0400;
   localparam logic [31:0] VS  = 32'h0000_0040;
`ifdef IRQ_CTRL_NEST_EN
   localparam bit NEST = 1'b1;
`else
   localparam bit NEST = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           in_RST = 1'b1;
   logic           en = 1'b1;
   logic [NUM-1:0] irq_in = '0;
   logic [31:0]    resume_pc = '0;
   logic           wb_eret = 1'b0;
   logic           int_ack = 1'b0;
   logic           int_req;
   logic [31:0]    int_addr, epc;
   logic [NUM-1:0] pending, in_service;
   logic           eret_err;

   int total = 0;
   int bad   = 0;

   irq_ctrl #(.NUM_IRQ(NUM), .VEC_BASE(VB), .VEC_STRIDE(VS)) dut (
      .clk        (clk),
      .in_RST     (in_RST),
      .en         (en),
      .irq_in     (irq_in),
      .resume_pc  (resume_pc),
      .wb_eret    (wb_eret),
      .int_ack    (int_ack),
      .int_req    (int_req),
      .int_addr   (int_addr),
      .epc        (epc),
      .pending    (pending),
      .in_service (in_service),
      .eret_err   (eret_err)
   );

   always #5 clk = ~clk;

   // Reference model: sample history per source, pending/in-service sets and an EPC queue.
   logic [3:0]     m_hist [NUM];
   logic [NUM-1:0] m_pend, m_insvc;
   bit             m_req, m_err;
   int             m_sel;
   logic [31:0]    m_stack [$];

   function automatic int highest(input logic [NUM-1:0] m);
      int r = -1;
      for (int i = 0; i < NUM; i++) if (m[i]) r = i;
      return r;
   endfunction

   function automatic logic [31:0] m_addr();
      return m_req ? VB + 32'(m_sel) * VS : 32'h0;
   endfunction

   function automatic logic [31:0] m_epc();
      return (m_stack.size() == 0) ? 32'h0 : m_stack[$];
   endfunction

   always @(posedge clk) begin
      logic [NUM-1:0] new_edges;
      int hi, win;
      bit do_eret;
      if (in_RST) begin
         for (int i = 0; i < NUM; i++) m_hist[i] = '0;
         m_pend = '0; m_insvc = '0; m_req = 0; m_err = 0; m_sel = 0;
         m_stack.delete();
      end else begin
         for (int i = 0; i < NUM; i++) begin
            new_edges[i] = m_hist[i][2] & ~m_hist[i][3];
            m_hist[i] = {m_hist[i][2:0], irq_in[i]};
         end
         hi  = highest(m_insvc);
         win = -1;
         for (int i = 0; i < NUM; i++)
            if (m_pend[i] && (NEST ? (i > hi) : (hi == -1))) win = i;
         do_eret = wb_eret && en;
         if (do_eret) begin
            if (m_stack.size() == 0) m_err = 1;
            else begin
               void'(m_stack.pop_back());
               if (NEST) m_insvc[hi] = 1'b0;
               else m_insvc = '0;
            end
         end
         if (en) begin
            if (!m_req) begin
               if (!do_eret && win >= 0) begin m_req = 1; m_sel = win; end
            end else if (int_ack) begin
               m_pend[m_sel] = 1'b0;
               m_insvc[m_sel] = 1'b1;
               m_stack.push_back(resume_pc);
               m_req = 0;
            end
         end
         m_pend = m_pend | new_edges;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [NUM-1:0] m);
      irq_in = m;
      tick();
      irq_in = '0;
   endtask

   task automatic ack(input logic [31:0] pc);
      int_ack = 1'b1; resume_pc = pc;
      tick();
      int_ack = 1'b0;
   endtask

   task automatic eret();
      wb_eret = 1'b1;
      tick();
      wb_eret = 1'b0;
   endtask

   task automatic wait_req(input int budget, output bit got);
      got = 0;
      for (int n = 0; n < budget && !got; n++) begin
         if (int_req === 1'b1) got = 1;
         else tick();
      end
      if (int_req === 1'b1) got = 1;
   endtask

   task automatic test_reset();
      in_RST = 1'b1; irq_in = 3'b111; int_ack = 1'b1; wb_eret = 1'b1;
      tick(); tick();
      in_RST = 1'b0; irq_in = '0; int_ack = 1'b0; wb_eret = 1'b0;
      total++; if (int_req !== 1'b0) begin bad++; $display("FAIL rst_int_req got=%b exp=0", int_req); end
      total++; if (int_addr !== 32'h0) begin bad++; $display("FAIL rst_int_addr got=%h exp=0", int_addr); end
      total++; if (epc !== 32'h0) begin bad++; $display("FAIL rst_epc got=%h exp=0", epc); end
      total++; if (pending !== 3'b000) begin bad++; $display("FAIL rst_pending got=%b exp=000", pending); end
      total++; if (in_service !== 3'b000) begin bad++; $display("FAIL rst_in_service got=%b exp=000", in_service); end
      total++; if (eret_err !== 1'b0) begin bad++; $display("FAIL rst_eret_err got=%b exp=0", eret_err); end
   endtask

   task automatic test_latency();
      pulse(3'b001);
      tick(); tick();
      total++; if (pending !== 3'b000) begin bad++; $display("FAIL lat_pend_early got=%b exp=000", pending); end
      tick();
      total++; if (pending !== 3'b001) begin bad++; $display("FAIL lat_pend got=%b exp=001", pending); end
      total++; if (int_req !== 1'b0) begin bad++; $display("FAIL lat_req_early got=%b exp=0", int_req); end
      tick();
      total++; if (int_req !== 1'b1) begin bad++; $display("FAIL lat_req got=%b exp=1", int_req); end
      total++; if (int_addr !== 32'h400) begin bad++; $display("FAIL lat_addr got=%h exp=400", int_addr); end
      ack(32'h100);
      total++; if (int_req !== 1'b0) begin bad++; $display("FAIL lat_req_drop got=%b exp=0", int_req); end
      total++; if (epc !== 32'h100) begin bad++; $display("FAIL lat_epc got=%h exp=100", epc); end
      total++; if (in_service !== 3'b001) begin bad++; $display("FAIL lat_insvc got=%b exp=001", in_service); end
      total++; if (pending !== 3'b000) begin bad++; $display("FAIL lat_pend_clr got=%b exp=000", pending); end
   endtask

   task automatic test_nesting();
      bit got;
      pulse(3'b100);
`ifdef IRQ_CTRL_NEST_EN
      wait_req(10, got);
      total++; if (got !== 1'b1) begin bad++; $display("FAIL nest_req_timeout got=%b exp=1", got); end
      total++; if (int_addr !== 32'h480) begin bad++; $display("FAIL nest_addr got=%h exp=480", int_addr); end
      ack(32'h404);
      total++; if (epc !== 32'h404) begin bad++; $display("FAIL nest_epc got=%h exp=404", epc); end
      total++; if (in_service !== 3'b101) begin bad++; $display("FAIL nest_insvc got=%b exp=101", in_service); end
      eret();
      total++; if (epc !== 32'h100) begin bad++; $display("FAIL nest_pop_epc got=%h exp=100", epc); end
      total++; if (in_service !== 3'b001) begin bad++; $display("FAIL nest_pop_insvc got=%b exp=001", in_service); end
      eret();
      total++; if (in_service !== 3'b000) begin bad++; $display("FAIL nest_pop2_insvc got=%b exp=000", in_service); end
      total++; if (epc !== 32'h0) begin bad++; $display("FAIL nest_pop2_epc got=%h exp=0", epc); end
`else
      repeat (8) tick();
      total++; if (int_req !== 1'b0) begin bad++; $display("FAIL flat_no_req got=%b exp=0", int_req); end
      total++; if (pending !== 3'b100) begin bad++; $display("FAIL flat_pend got=%b exp=100", pending); end
      eret();
      total++; if (in_service !== 3'b000) begin bad++; $display("FAIL flat_insvc got=%b exp=000", in_service); end
      total++; if (epc !== 32'h0) begin bad++; $display("FAIL flat_epc0 got=%h exp=0", epc); end
      wait_req(4, got);
      total++; if (got !== 1'b1) begin bad++; $display("FAIL flat_req_timeout got=%b exp=1", got); end
      total++; if (int_addr !== 32'h480) begin bad++; $display("FAIL flat_addr got=%h exp=480", int_addr); end
      ack(32'h404);
      total++; if (epc !== 32'h404) begin bad++; $display("FAIL flat_epc got=%h exp=404", epc); end
      total++; if (in_service !== 3'b100) begin bad++; $display("FAIL flat_insvc2 got=%b exp=100", in_service); end
      eret();
`endif
   endtask

   task automatic test_masked();
      bit got;
      pulse(3'b010);
      wait_req(10, got);
      total++; if (got !== 1'b1) begin bad++; $display("FAIL mask_req1_timeout got=%b exp=1", got); end
      ack(32'h200);
      pulse(3'b001);
      repeat (5) tick();
      total++; if (pending !== 3'b001) begin bad++; $display("FAIL mask_pend got=%b exp=001", pending); end
      total++; if (int_req !== 1'b0) begin bad++; $display("FAIL mask_no_req got=%b exp=0", int_req); end
      eret();
      wait_req(2, got);
      total++; if (got !== 1'b1) begin bad++; $display("FAIL mask_req0_timeout got=%b exp=1", got); end
      total++; if (int_addr !== 32'h400) begin bad++; $display("FAIL mask_addr got=%h exp=400", int_addr); end
      ack(32'h210);
      eret();
      total++; if (in_service !== 3'b000) begin bad++; $display("FAIL mask_clean got=%b exp=000", in_service); end
   endtask

   task automatic test_simultaneous();
      bit got;
      pulse(3'b011);
      wait_req(10, got);
      total++; if (got !== 1'b1) begin bad++; $display("FAIL sim_req1_timeout got=%b exp=1", got); end
      total++; if (int_addr !== 32'h440) begin bad++; $display("FAIL sim_addr1 got=%h exp=440", int_addr); end
      ack(32'h500);
      eret();
      wait_req(4, got);
      total++; if (got !== 1'b1) begin bad++; $display("FAIL sim_req0_timeout got=%b exp=1", got); end
      total++; if (int_addr !== 32'h400) begin bad++; $display("FAIL sim_addr0 got=%h exp=400", int_addr); end
      ack(32'h504);
      eret();
      total++; if (pending !== 3'b000) begin bad++; $display("FAIL sim_pend got=%b exp=000", pending); end
   endtask

   task automatic test_eret_err_and_stall();
      bit got;
      eret();
      total++; if (eret_err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", eret_err); end
      total++; if (in_service !== 3'b000) begin bad++; $display("FAIL err_insvc got=%b exp=000", in_service); end
      total++; if (int_req !== 1'b0) begin bad++; $display("FAIL err_req got=%b exp=0", int_req); end
      pulse(3'b001);
      wait_req(10, got);
      total++; if (got !== 1'b1) begin bad++; $display("FAIL stall_req_timeout got=%b exp=1", got); end
      en = 1'b0; int_ack = 1'b1; resume_pc = 32'h300;
      tick(); tick();
      total++; if (int_req !== 1'b1) begin bad++; $display("FAIL stall_hold got=%b exp=1", int_req); end
      total++; if (epc !== 32'h0) begin bad++; $display("FAIL stall_no_push got=%h exp=0", epc); end
      total++; if (in_service !== 3'b000) begin bad++; $display("FAIL stall_insvc got=%b exp=000", in_service); end
      en = 1'b1;
      tick();
      int_ack = 1'b0;
      total++; if (epc !== 32'h300) begin bad++; $display("FAIL stall_push got=%h exp=300", epc); end
      total++; if (in_service !== 3'b001) begin bad++; $display("FAIL stall_insvc2 got=%b exp=001", in_service); end
      eret();
      total++; if (eret_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", eret_err); end
   endtask

   task automatic test_reset_mid();
      bit got;
      pulse(3'b001);
      wait_req(10, got);
      total++; if (got !== 1'b1) begin bad++; $display("FAIL rmid_req_timeout got=%b exp=1", got); end
      ack(32'h700);
      pulse(3'b010);
      in_RST = 1'b1;
      tick();
      in_RST = 1'b0;
      total++; if (in_service !== 3'b000) begin bad++; $display("FAIL rmid_insvc got=%b exp=000", in_service); end
      total++; if (epc !== 32'h0) begin bad++; $display("FAIL rmid_epc got=%h exp=0", epc); end
      total++; if (eret_err !== 1'b0) begin bad++; $display("FAIL rmid_err got=%b exp=0", eret_err); end
      repeat (6) tick();
      total++; if (pending !== 3'b000) begin bad++; $display("FAIL rmid_lost got=%b exp=000", pending); end
      total++; if (int_req !== 1'b0) begin bad++; $display("FAIL rmid_req got=%b exp=0", int_req); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 2000; c++) begin
         in_RST    = ($urandom_range(0, 199) == 0);
         en        = ($urandom_range(0, 9) != 0);
         irq_in    = NUM'($urandom) & NUM'($urandom) & NUM'($urandom);
         wb_eret   = ($urandom_range(0, 19) == 0);
         int_ack   = ($urandom_range(0, 2) == 0);
         resume_pc = $urandom;
         tick();
         total++; if (int_req !== m_req) begin bad++; $display("FAIL rnd_req c=%0d got=%b exp=%b", c, int_req, m_req); end
         total++; if (int_addr !== m_addr()) begin bad++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, int_addr, m_addr()); end
         total++; if (epc !== m_epc()) begin bad++; $display("FAIL rnd_epc c=%0d got=%h exp=%h", c, epc, m_epc()); end
         total++; if (pending !== m_pend) begin bad++; $display("FAIL rnd_pend c=%0d got=%b exp=%b", c, pending, m_pend); end
         total++; if (in_service !== m_insvc) begin bad++; $display("FAIL rnd_insvc c=%0d got=%b exp=%b", c, in_service, m_insvc); end
         total++; if (eret_err !== m_err) begin bad++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, eret_err, m_err); end
      end
      in_RST = 1'b0; en = 1'b1; irq_in = '0; wb_eret = 1'b0; int_ack = 1'b0;
   endtask

   initial begin
      #1;
      test_reset();
      test_latency();
      test_nesting();
      test_masked();
      test_simultaneous();
      test_eret_err_and_stall();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog_timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Prioritised, nestable external-interrupt controller sitting directly upstream of the pipelined CPU's PC-select logic.
- Synchronises raw board interrupt lines, latches edges as pending, and presents a redirect request with a vector address alongside the existing eret redirect.
- Keeps an EPC stack so that eret returns to the interrupted instruction.

Parameters:
- NUM_IRQ, 3: number of interrupt sources; source index NUM_IRQ-1 has the highest priority.
- VEC_BASE, 32'h0000_0400: vector address of source 0.
- VEC_STRIDE, 32'h0000_0040: vector spacing; vector(i) = VEC_BASE + i*VEC_STRIDE, 32-bit wrap.

Ports:
- clk  in  1  core clock.
- in_RST  in  1  synchronous, active-high reset.
- en  in  1  pipeline enable (low = pipeline stalled).
- irq_in  in  NUM_IRQ  raw asynchronous interrupt levels.
- resume_pc  in  32  address of the oldest unretired instruction; this becomes the EPC.
- wb_eret  in  1  eret retiring in WB.
- int_ack  in  1  pipeline has taken the redirect.
- int_req  out  1  redirect request.
- int_addr  out  32  vector address, valid while int_req is high.
- epc  out  32  top of the EPC stack (the eret target).
- pending  out  NUM_IRQ  latched, not-yet-serviced edges.
- in_service  out  NUM_IRQ  handlers currently active.
- eret_err  out  1  sticky flag: eret issued while the stack was empty.

Behaviour:
- Reset: all outputs 0; stack empty; synchroniser flops 0; state IDLE.
- Per source: 2-flop synchroniser (s1, s2), then s3. edge = s2 & ~s3. Each edge sets pending[i]. Levels are ignored; only rising edges count.
- Latency: irq_in high at clock edge k gives pending visible after edge k+3 and int_req high after edge k+4, provided the request is eligible.
- Eligibility: a source is eligible when pending[i]=1 and its index is greater than the highest set in_service bit (none set counts as -1). The winner is the highest eligible index.
- FSM IDLE: if en=1 and an eligible source exists, latch sel=winner and go to REQ.
- FSM REQ: int_req=1; int_addr=vector(sel), held stable regardless of new edges.
  - On int_ack=1: clear pending[sel], set in_service[sel], push resume_pc onto the stack, then go to IDLE.
  - int_req deasserts in the cycle after the ack.
  - int_ack outside REQ is ignored.
- eret (wb_eret=1 and en=1), in any state:
  - Pop the stack and clear the highest set in_service bit.
  - Empty stack: no state change; set eret_err (cleared only by reset).
  - eret and an eligible request in the same IDLE cycle: apply the eret only; re-evaluate eligibility next cycle.
  - eret and int_ack in the same cycle: pop first, then push, so net depth is unchanged.
- epc shows the top of stack combinationally from the registered stack; 0 when the stack is empty.
- An edge on a source that is already pending merges into the existing pending bit; it is not counted twice.
- An edge on a source that is in service sets pending; that source is serviced after its eret.
- en=0: synchronisers and pending capture keep running; there are no FSM, stack, or eret updates, and int_req holds its value.
- Stack depth is NUM_IRQ. Overflow cannot occur, because a push requires strictly higher priority than every active handler.
- in_RST asserted mid-REQ or with nesting active: everything clears on the next edge; pending edges in flight are lost.

Optional Feature:
- IRQ_CTRL_NEST_EN defined: nesting as above.
- IRQ_CTRL_NEST_EN undefined:
  - A source is eligible only when in_service is all-zero.
  - The stack collapses to a single EPC register.
  - eret clears all of in_service.
  - Priority still selects among simultaneously pending sources.

Decomposition:
- Package irq_ctrl_pkg:
  - state enum (IDLE, REQ);
  - NUM_IRQ default;
  - VEC_BASE and VEC_STRIDE constants;
  - function vec_addr(idx);
  - function top_index(mask), returning -1 for an empty mask.
- Sub-module irq_sync_edge (2-flop synchroniser plus edge detect, one per source), generated NUM_IRQ times.

Test Plan:
- Reset, then pulse irq_in[0] high for 1 cycle; int_ack on the first int_req cycle with resume_pc=0x100 -> int_req rises 4 edges after the first sampled-high edge; int_addr=0x400; epc=0x100; in_service=3'b001.
- irq0 handler active (EPC 0x100); irq_in[2] edge; ack with resume_pc=0x404 -> int_addr=0x480; epc=0x404; in_service=3'b101. eret -> epc=0x100, in_service=3'b001. eret -> in_service=0, epc=0.
- irq1 handler active; irq_in[0] edge -> pending=3'b001 and no int_req. eret -> int_req with int_addr=0x400 follows within 2 cycles.
- Edges on irq_in[0] and irq_in[1] in the same cycle -> first int_addr=0x440. After ack and eret, second int_addr=0x400.
- eret with the stack empty -> eret_err=1, no other change; it stays 1 until in_RST. en=0 with int_req high and int_ack=1 -> no push, request still held.
- Build without IRQ_CTRL_NEST_EN: irq2 edge during an active irq0 handler -> no int_req until eret, then int_addr=0x480.
